// File: rtl/svc_sram_pkg.sv
// Shared types for the AXI SRAM command path: grant side and arbitration modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   grant_t            which command stream owns the SRAM port
//   ARB_RR/ARB_WR_PRI/ARB_RD_PRI  arbitration mode encodings
//   CNT_W              width of the consecutive-grant and outstanding-read counters
//   other_side()       the opposite grant side
package svc_sram_pkg;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_t;

   localparam int ARB_RR     = 0;
   localparam int ARB_WR_PRI = 1;
   localparam int ARB_RD_PRI = 2;

   // MAX_CONSEC and MAX_RD_OUTSTANDING are both limited to 255.
   localparam int CNT_W = 8;

   function automatic grant_t other_side(input grant_t g);
      return (g == GRANT_WR) ? GRANT_RD : GRANT_WR;
   endfunction

endpackage

// File: rtl/svc_sram_arb_grant.sv
// Grant decision between the write and read SRAM command streams.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the top gates the decision with its output-register load.
//
// Ports:
//   wr_req, rd_req   side is requesting (rd_req already qualified by the read limit)
//   last_grant       side that won the most recent accepted command
//   consec           back-to-back grants already given to last_grant
//   grant            winning side (meaningful only when a request is present)
module svc_sram_arb_grant
   import svc_sram_pkg::*;
#(
   parameter int MODE       = ARB_RR,
   parameter int MAX_CONSEC = 4
) (
   input  logic             wr_req,
   input  logic             rd_req,
   input  grant_t           last_grant,
   input  logic [CNT_W-1:0] consec,
   output grant_t           grant
);

   localparam grant_t           FAV  = (MODE == ARB_RD_PRI) ? GRANT_RD : GRANT_WR;
   localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CONSEC);

   always_comb begin
      grant = last_grant;
      if (wr_req && !rd_req) begin
         grant = GRANT_WR;
      end else if (rd_req && !wr_req) begin
         grant = GRANT_RD;
      end else if (wr_req && rd_req) begin
         if (MODE == ARB_RR) begin
            grant = other_side(last_grant);
         end else if ((last_grant == FAV) && (consec == MAXC)) begin
            // Favoured side has used up its run; the waiting side gets one slot.
            grant = other_side(FAV);
         end else begin
            grant = FAV;
         end
      end
   end

endmodule

// File: rtl/svc_axi_sram_cmd_arb.sv
// Arbitrates AXI read/write SRAM command streams onto one registered SRAM command port.
// Latency: command accepted at cycle N appears on sram_cmd_* at cycle N+1.
// Backpressure: input readys drop while the output register holds an unaccepted command.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wr_cmd_valid/ready, addr/data/strb   write command stream
//   rd_cmd_valid/ready, id/addr          read command stream
//   sram_cmd_valid/ready, id/addr/wr_en/wr_data/wr_strb   registered SRAM command
//   sram_rd_resp_valid/ready        monitored; each handshake retires one outstanding read
module svc_axi_sram_cmd_arb
   import svc_sram_pkg::*;
#(
   parameter int ADDR_WIDTH         = 19,
   parameter int DATA_WIDTH         = 16,
   parameter int ID_WIDTH           = 4,
   parameter int STRB_WIDTH         = DATA_WIDTH / 8,
   parameter int MODE               = 0,
   parameter int MAX_CONSEC         = 4,
   parameter int MAX_RD_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  wr_cmd_valid,
   output logic                  wr_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
   input  logic [DATA_WIDTH-1:0] wr_cmd_data,
   input  logic [STRB_WIDTH-1:0] wr_cmd_strb,

   input  logic                  rd_cmd_valid,
   output logic                  rd_cmd_ready,
   input  logic [ID_WIDTH-1:0]   rd_cmd_id,
   input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,

   output logic                  sram_cmd_valid,
   input  logic                  sram_cmd_ready,
   output logic [ID_WIDTH-1:0]   sram_cmd_id,
   output logic [ADDR_WIDTH-1:0] sram_cmd_addr,
   output logic                  sram_cmd_wr_en,
   output logic [DATA_WIDTH-1:0] sram_cmd_wr_data,
   output logic [STRB_WIDTH-1:0] sram_cmd_wr_strb,

   input  logic                  sram_rd_resp_valid,
   input  logic                  sram_rd_resp_ready
);

   localparam logic [CNT_W-1:0] MAXC  = CNT_W'(MAX_CONSEC);
   localparam logic [CNT_W-1:0] MAXRD = CNT_W'(MAX_RD_OUTSTANDING);

   logic             load;
   logic             rd_ok;
   logic             accept;
   logic             rd_retire;
   grant_t           grant;
   grant_t           last_grant;
   logic [CNT_W-1:0] consec;
   logic [CNT_W-1:0] rd_cnt;

   // The output register may take a new command when empty or being drained.
   assign load      = !sram_cmd_valid || sram_cmd_ready;
   // Reads beyond the outstanding cap are hidden from the arbiter entirely,
   // so a blocked read never costs the write side a slot.
   assign rd_ok     = rd_cmd_valid && (rd_cnt < MAXRD);
   assign rd_retire = sram_rd_resp_valid && sram_rd_resp_ready;

   svc_sram_arb_grant #(
      .MODE       (MODE),
      .MAX_CONSEC (MAX_CONSEC)
   ) u_grant (
      .wr_req     (wr_cmd_valid),
      .rd_req     (rd_ok),
      .last_grant (last_grant),
      .consec     (consec),
      .grant      (grant)
   );

   // rst_n gating keeps both readys low while reset is asserted.
   assign wr_cmd_ready = rst_n && load && wr_cmd_valid && (grant == GRANT_WR);
   assign rd_cmd_ready = rst_n && load && rd_ok && (grant == GRANT_RD);
   assign accept       = wr_cmd_ready || rd_cmd_ready;

   // Registered SRAM command. Payload only changes on an accept, so it is
   // stable whenever a command is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sram_cmd_valid   <= 1'b0;
         sram_cmd_id      <= '0;
         sram_cmd_addr    <= '0;
         sram_cmd_wr_en   <= 1'b0;
         sram_cmd_wr_data <= '0;
         sram_cmd_wr_strb <= '0;
      end else if (load) begin
         sram_cmd_valid <= accept;
         if (wr_cmd_ready) begin
            sram_cmd_id      <= '0;
            sram_cmd_addr    <= wr_cmd_addr;
            sram_cmd_wr_en   <= 1'b1;
            sram_cmd_wr_data <= wr_cmd_data;
            sram_cmd_wr_strb <= wr_cmd_strb;
         end else if (rd_cmd_ready) begin
            sram_cmd_id      <= rd_cmd_id;
            sram_cmd_addr    <= rd_cmd_addr;
            sram_cmd_wr_en   <= 1'b0;
            sram_cmd_wr_data <= '0;
            sram_cmd_wr_strb <= '0;
         end
      end
   end

   // Arbitration history. Reset leaves last_grant on the write side so the
   // first contested round-robin decision favours reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= GRANT_WR;
         consec     <= '0;
      end else if (accept) begin
         last_grant <= grant;
         if (grant == last_grant) begin
            consec <= (consec < MAXC) ? consec + 1'b1 : consec;
         end else begin
            consec <= CNT_W'(1);
         end
      end
   end

   // Outstanding reads: issue and retire in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_cnt <= '0;
      end else begin
         case ({rd_cmd_ready, rd_retire})
            2'b10:   rd_cnt <= rd_cnt + 1'b1;
            2'b01:   rd_cnt <= rd_cnt - 1'b1;
            default: rd_cnt <= rd_cnt;
         endcase
      end
   end

`ifdef FORMAL
   // A response with nothing outstanding means the upstream read path is broken.
   always_ff @(posedge clk) begin
      if (rst_n && rd_retire) begin
         assert (rd_cnt != '0);
      end
   end
`endif

endmodule

// File: tb/tb_svc_axi_sram_cmd_arb.sv
module tb_svc_axi_sram_cmd_arb;
   import svc_sram_pkg::*;

   logic clk;
   int   vecs;
   int   miscmp;

   // Instance A: round-robin, read cap 4.
   logic        a_rst_n;
   logic        a_wr_cmd_valid, a_wr_cmd_ready;
   logic [18:0] a_wr_cmd_addr;
   logic [15:0] a_wr_cmd_data;
   logic [1:0]  a_wr_cmd_strb;
   logic        a_rd_cmd_valid, a_rd_cmd_ready;
   logic [3:0]  a_rd_cmd_id;
   logic [18:0] a_rd_cmd_addr;
   logic        a_sram_cmd_valid, a_sram_cmd_ready;
   logic [3:0]  a_sram_cmd_id;
   logic [18:0] a_sram_cmd_addr;
   logic        a_sram_cmd_wr_en;
   logic [15:0] a_sram_cmd_wr_data;
   logic [1:0]  a_sram_cmd_wr_strb;
   logic        a_resp_valid, a_resp_ready;

   // Instance B: write priority, MAX_CONSEC 4, read cap 2.
   logic        b_rst_n;
   logic        b_wr_cmd_valid, b_wr_cmd_ready;
   logic [18:0] b_wr_cmd_addr;
   logic [15:0] b_wr_cmd_data;
   logic [1:0]  b_wr_cmd_strb;
   logic        b_rd_cmd_valid, b_rd_cmd_ready;
   logic [3:0]  b_rd_cmd_id;
   logic [18:0] b_rd_cmd_addr;
   logic        b_sram_cmd_valid, b_sram_cmd_ready;
   logic [3:0]  b_sram_cmd_id;
   logic [18:0] b_sram_cmd_addr;
   logic        b_sram_cmd_wr_en;
   logic [15:0] b_sram_cmd_wr_data;
   logic [1:0]  b_sram_cmd_wr_strb;
   logic        b_resp_valid, b_resp_ready;

   svc_axi_sram_cmd_arb #(
      .MODE (0), .MAX_CONSEC (4), .MAX_RD_OUTSTANDING (4)
   ) a_dut (
      .clk                (clk),
      .rst_n              (a_rst_n),
      .wr_cmd_valid       (a_wr_cmd_valid),
      .wr_cmd_ready       (a_wr_cmd_ready),
      .wr_cmd_addr        (a_wr_cmd_addr),
      .wr_cmd_data        (a_wr_cmd_data),
      .wr_cmd_strb        (a_wr_cmd_strb),
      .rd_cmd_valid       (a_rd_cmd_valid),
      .rd_cmd_ready       (a_rd_cmd_ready),
      .rd_cmd_id          (a_rd_cmd_id),
      .rd_cmd_addr        (a_rd_cmd_addr),
      .sram_cmd_valid     (a_sram_cmd_valid),
      .sram_cmd_ready     (a_sram_cmd_ready),
      .sram_cmd_id        (a_sram_cmd_id),
      .sram_cmd_addr      (a_sram_cmd_addr),
      .sram_cmd_wr_en     (a_sram_cmd_wr_en),
      .sram_cmd_wr_data   (a_sram_cmd_wr_data),
      .sram_cmd_wr_strb   (a_sram_cmd_wr_strb),
      .sram_rd_resp_valid (a_resp_valid),
      .sram_rd_resp_ready (a_resp_ready)
   );

   svc_axi_sram_cmd_arb #(
      .MODE (1), .MAX_CONSEC (4), .MAX_RD_OUTSTANDING (2)
   ) b_dut (
      .clk                (clk),
      .rst_n              (b_rst_n),
      .wr_cmd_valid       (b_wr_cmd_valid),
      .wr_cmd_ready       (b_wr_cmd_ready),
      .wr_cmd_addr        (b_wr_cmd_addr),
      .wr_cmd_data        (b_wr_cmd_data),
      .wr_cmd_strb        (b_wr_cmd_strb),
      .rd_cmd_valid       (b_rd_cmd_valid),
      .rd_cmd_ready       (b_rd_cmd_ready),
      .rd_cmd_id          (b_rd_cmd_id),
      .rd_cmd_addr        (b_rd_cmd_addr),
      .sram_cmd_valid     (b_sram_cmd_valid),
      .sram_cmd_ready     (b_sram_cmd_ready),
      .sram_cmd_id        (b_sram_cmd_id),
      .sram_cmd_addr      (b_sram_cmd_addr),
      .sram_cmd_wr_en     (b_sram_cmd_wr_en),
      .sram_cmd_wr_data   (b_sram_cmd_wr_data),
      .sram_cmd_wr_strb   (b_sram_cmd_wr_strb),
      .sram_rd_resp_valid (b_resp_valid),
      .sram_rd_resp_ready (b_resp_ready)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_rd;
      clk    = 1'b0;
      vecs   = 0;
      miscmp = 0;

      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_wr_cmd_valid = 1'b1; a_rd_cmd_valid = 1'b1;
      a_wr_cmd_addr = 19'h00200; a_wr_cmd_data = 16'hBEEF; a_wr_cmd_strb = 2'b10;
      a_rd_cmd_id = 4'h5; a_rd_cmd_addr = 19'h00100;
      a_sram_cmd_ready = 1'b1; a_resp_valid = 1'b0; a_resp_ready = 1'b0;
      b_wr_cmd_valid = 1'b0; b_rd_cmd_valid = 1'b0;
      b_wr_cmd_addr = 19'h00400; b_wr_cmd_data = 16'h1111; b_wr_cmd_strb = 2'b11;
      b_rd_cmd_id = 4'h7; b_rd_cmd_addr = 19'h00300;
      b_sram_cmd_ready = 1'b1; b_resp_valid = 1'b0; b_resp_ready = 1'b0;

      // Reset state, with both valids high.
      repeat (3) step();
      chk("rst_valid",  32'(a_sram_cmd_valid),   32'h0);
      chk("rst_wr_en",  32'(a_sram_cmd_wr_en),   32'h0);
      chk("rst_addr",   32'(a_sram_cmd_addr),    32'h0);
      chk("rst_id",     32'(a_sram_cmd_id),      32'h0);
      chk("rst_data",   32'(a_sram_cmd_wr_data), 32'h0);
      chk("rst_strb",   32'(a_sram_cmd_wr_strb), 32'h0);
      chk("rst_wr_rdy", 32'(a_wr_cmd_ready),     32'h0);
      chk("rst_rd_rdy", 32'(a_rd_cmd_ready),     32'h0);
      chk("rst_rd_cnt", 32'(a_dut.rd_cnt),       32'h0);

      // Round-robin, both requesting: R,W,R,W,R,W.
      a_rst_n = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         exp_rd = (i % 2 == 0);
         chk("rr_rd_rdy", 32'(a_rd_cmd_ready), 32'(exp_rd));
         chk("rr_wr_rdy", 32'(a_wr_cmd_ready), 32'(!exp_rd));
         step();
         chk("rr_valid", 32'(a_sram_cmd_valid), 32'h1);
         chk("rr_wr_en", 32'(a_sram_cmd_wr_en), 32'(!exp_rd));
         chk("rr_addr",  32'(a_sram_cmd_addr),  exp_rd ? 32'h100 : 32'h200);
         chk("rr_id",    32'(a_sram_cmd_id),    exp_rd ? 32'h5 : 32'h0);
         chk("rr_data",  32'(a_sram_cmd_wr_data), exp_rd ? 32'h0 : 32'hBEEF);
         chk("rr_strb",  32'(a_sram_cmd_wr_strb), exp_rd ? 32'h0 : 32'h2);
      end
      a_wr_cmd_valid = 1'b0; a_rd_cmd_valid = 1'b0;
      step();
      chk("idle_valid", 32'(a_sram_cmd_valid), 32'h0);
      chk("rr_rd_cnt",  32'(a_dut.rd_cnt),     32'h3);

      // Retire two reads.
      a_resp_valid = 1'b1; a_resp_ready = 1'b1;
      repeat (2) step();
      a_resp_valid = 1'b0;
      chk("retire_cnt", 32'(a_dut.rd_cnt), 32'h1);

      // Issue and retire in the same cycle.
      a_rd_cmd_valid = 1'b1; a_resp_valid = 1'b1;
      #1;
      chk("same_rd_rdy", 32'(a_rd_cmd_ready), 32'h1);
      step();
      a_rd_cmd_valid = 1'b0; a_resp_valid = 1'b0;
      chk("same_cnt",   32'(a_dut.rd_cnt),     32'h1);
      chk("same_wr_en", 32'(a_sram_cmd_wr_en), 32'h0);
      chk("same_valid", 32'(a_sram_cmd_valid), 32'h1);
      step();

      // Backpressure: write 0x1234 loads into the empty register, then stalls.
      a_sram_cmd_ready = 1'b0;
      a_wr_cmd_valid = 1'b1; a_wr_cmd_addr = 19'h01234; a_wr_cmd_data = 16'h5A5A;
      a_wr_cmd_strb = 2'b11;
      #1;
      chk("bp_load_rdy", 32'(a_wr_cmd_ready), 32'h1);
      step();
      a_wr_cmd_addr = 19'h02222; a_rd_cmd_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_wr_rdy", 32'(a_wr_cmd_ready),  32'h0);
         chk("bp_rd_rdy", 32'(a_rd_cmd_ready),  32'h0);
         step();
         chk("bp_valid",  32'(a_sram_cmd_valid), 32'h1);
         chk("bp_addr",   32'(a_sram_cmd_addr),  32'h1234);
         chk("bp_data",   32'(a_sram_cmd_wr_data), 32'h5A5A);
         chk("bp_strb",   32'(a_sram_cmd_wr_strb), 32'h3);
      end
      a_sram_cmd_ready = 1'b1;
      #1;
      chk("bp_rel_rd_rdy", 32'(a_rd_cmd_ready), 32'h1);
      chk("bp_rel_wr_rdy", 32'(a_wr_cmd_ready), 32'h0);
      step();
      chk("bp_next_wr_en", 32'(a_sram_cmd_wr_en), 32'h0);
      chk("bp_next_addr",  32'(a_sram_cmd_addr),  32'h100);
      step();
      chk("bp_w2_addr",    32'(a_sram_cmd_addr),  32'h2222);
      chk("bp_w2_wr_en",   32'(a_sram_cmd_wr_en), 32'h1);
      step();
      chk("bp_r3_addr",    32'(a_sram_cmd_addr),  32'h100);

      // Leave a read pending with three outstanding, then reset.
      a_sram_cmd_ready = 1'b0; a_wr_cmd_valid = 1'b0; a_rd_cmd_valid = 1'b0;
      step();
      chk("pend_valid", 32'(a_sram_cmd_valid), 32'h1);
      chk("pend_cnt",   32'(a_dut.rd_cnt),     32'h3);
      a_rst_n = 1'b0; a_wr_cmd_valid = 1'b1; a_rd_cmd_valid = 1'b1;
      #1;
      chk("mrst_wr_rdy", 32'(a_wr_cmd_ready), 32'h0);
      chk("mrst_rd_rdy", 32'(a_rd_cmd_ready), 32'h0);
      step();
      chk("mrst_valid", 32'(a_sram_cmd_valid), 32'h0);
      chk("mrst_cnt",   32'(a_dut.rd_cnt),     32'h0);
      chk("mrst_addr",  32'(a_sram_cmd_addr),  32'h0);
      a_rst_n = 1'b1; a_sram_cmd_ready = 1'b1;
      #1;
      chk("post_rd_rdy", 32'(a_rd_cmd_ready), 32'h1);
      chk("post_wr_rdy", 32'(a_wr_cmd_ready), 32'h0);
      step();
      chk("post_wr_en", 32'(a_sram_cmd_wr_en), 32'h0);
      chk("post_valid", 32'(a_sram_cmd_valid), 32'h1);
      a_wr_cmd_valid = 1'b0; a_rd_cmd_valid = 1'b0;

      // Write priority with starvation limit: W,W,W,W,R,W,W,W,W,R.
      b_rst_n = 1'b1; b_wr_cmd_valid = 1'b1; b_rd_cmd_valid = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         exp_rd = (i == 4) || (i == 9);
         chk("pri_rd_rdy", 32'(b_rd_cmd_ready), 32'(exp_rd));
         step();
         chk("pri_wr_en", 32'(b_sram_cmd_wr_en), 32'(!exp_rd));
         chk("pri_addr",  32'(b_sram_cmd_addr),  exp_rd ? 32'h300 : 32'h400);
      end

      // Outstanding-read cap of 2 with reads queued and no responses.
      b_wr_cmd_valid = 1'b0; b_rd_cmd_valid = 1'b0; b_rst_n = 1'b0;
      repeat (2) step();
      b_rst_n = 1'b1; b_rd_cmd_valid = 1'b1;
      #1;
      step();
      chk("cap_r1_valid", 32'(b_sram_cmd_valid), 32'h1);
      chk("cap_r1_rdy",   32'(b_rd_cmd_ready),   32'h1);
      step();
      chk("cap_r2_valid", 32'(b_sram_cmd_valid), 32'h1);
      chk("cap_full_rdy", 32'(b_rd_cmd_ready),   32'h0);
      step();
      chk("cap_stall_valid", 32'(b_sram_cmd_valid), 32'h0);
      b_resp_valid = 1'b1; b_resp_ready = 1'b1;
      #1;
      chk("cap_resp_rdy", 32'(b_rd_cmd_ready), 32'h0);
      step();
      b_resp_valid = 1'b0;
      #1;
      chk("cap_free_rdy", 32'(b_rd_cmd_ready), 32'h1);
      step();
      chk("cap_r3_valid", 32'(b_sram_cmd_valid), 32'h1);
      chk("cap_r3_wr_en", 32'(b_sram_cmd_wr_en), 32'h0);
      chk("cap_r3_id",    32'(b_sram_cmd_id),    32'h7);
      chk("cap_r3_rdy",   32'(b_rd_cmd_ready),   32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
